// File: rtl/fat_pkg.sv
// Shared definitions for the A/B->N/R receive-side decoder: shadow state encoding
// (must match the transmitting FSM) and the per-sample decode table.
package fat_pkg;

  typedef enum logic [1:0] {
    ST_X = 2'b00,
    ST_Y = 2'b01,
    ST_Z = 2'b10
  } state_t;

  typedef struct packed {
    logic   valid;
    logic   bit_val;
    state_t next;
    logic   violation;
  } decode_t;

  // Recover the driven input bit from one (state, N, R) observation.
  function automatic decode_t decode(input state_t s, input logic n, input logic r);
    decode_t d;
    d.valid     = 1'b0;
    d.bit_val   = 1'b0;
    d.next      = s;
    d.violation = 1'b0;
    if (n && r) begin
      d.violation = 1'b1;
    end else begin
      case (s)
        ST_X: begin
          if (n) begin
            d.violation = 1'b1;
          end else begin
            d.valid   = 1'b1;
            d.bit_val = r;
            d.next    = r ? ST_Y : ST_Z;
          end
        end
        ST_Y: begin
          if (n || r) begin
            d.valid   = 1'b1;
            d.bit_val = n;
            d.next    = ST_Y;
          end else begin
            d.violation = 1'b1;
          end
        end
        ST_Z: begin
          if (n) begin
            d.valid   = 1'b1;
            d.bit_val = 1'b0;
            d.next    = ST_X;
          end else if (r) begin
            d.valid   = 1'b1;
            d.bit_val = 1'b1;
            d.next    = ST_Y;
          end else begin
            d.violation = 1'b1;
          end
        end
        default: d.violation = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/fat_fifo.sv
// Small synchronous FIFO for recovered words; a push while full only lands if a
// pop happens on the same edge.
module fat_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero when empty so the output never shows stale storage.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fat_decoder.sv
// Shadows the N/R signalling FSM, recovers its input bits, packs them LSB-first
// into words and queues them behind a valid/ready FIFO; resyncs after violations.
module fat_decoder
  import fat_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             N,
  input  logic             R,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sync,
  output logic             err,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  decode_t          dec;
  logic [CW-1:0]    bit_count;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;
  logic             push_pending;
  logic [WIDTH-1:0] push_data;
  logic             full;
  logic             empty;
  logic             pop;

  always_comb dec = decode(state, N, R);

  assign next_word = {dec.bit_val, shift_reg[WIDTH-1:1]};
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  // While unsynced only R alone is trusted, since every state answers R=1 with Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_X;
      sync         <= 1'b1;
      err          <= 1'b0;
      bit_count    <= '0;
      shift_reg    <= '0;
      push_pending <= 1'b0;
      push_data    <= '0;
    end else begin
      err          <= 1'b0;
      push_pending <= 1'b0;
      if (!sync) begin
        if (R && !N) begin
          state <= ST_Y;
          sync  <= 1'b1;
        end
      end else if (dec.violation) begin
        err       <= 1'b1;
        sync      <= 1'b0;
        bit_count <= '0;
        shift_reg <= '0;
      end else if (dec.valid) begin
        state <= dec.next;
        if (bit_count == CW'(WIDTH - 1)) begin
          push_pending <= 1'b1;
          push_data    <= next_word;
          bit_count    <= '0;
          shift_reg    <= '0;
        end else begin
          shift_reg <= next_word;
          bit_count <= bit_count + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_pending && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  fat_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_pending),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (out_data),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_fat_decoder.sv
// Directed bench for fat_decoder: reset, decode paths, violation/resync,
// FIFO backpressure and overflow, and reset mid-word.
module tb_fat_decoder;
  import fat_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             N = 1'b0;
  logic             R = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             sync;
  logic             err;
  logic             overflow;

  int     checks = 0;
  int     errors = 0;
  state_t enc_state = ST_X;

  always #5 clk = ~clk;

  fat_decoder #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .N        (N),
    .R        (R),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sync     (sync),
    .err      (err),
    .overflow (overflow)
  );

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_word(input string tag, input logic [WIDTH-1:0] observed,
                            input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one N/R sample just after an edge, then let the next edge take it.
  task automatic apply_stimulus(input logic n, input logic r);
    N = n;
    R = r;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    N = 1'b0;
    R = 1'b0;
    #1;
    check_bit("rst_sync_immediate", sync, 1'b1);
    check_bit("rst_valid_immediate", out_valid, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check_bit("rst_valid", out_valid, 1'b0);
    check_word("rst_data", out_data, 8'h00);
    check_bit("rst_sync", sync, 1'b1);
    check_bit("rst_err", err, 1'b0);
    check_bit("rst_overflow", overflow, 1'b0);
    rst_n = 1'b1;
    enc_state = ST_X;
  endtask

  // Transmit-side encoder: which N/R the FSM shows for a given bit in a given state.
  task automatic send_bit(input logic b);
    case (enc_state)
      ST_X: begin
        if (b) begin apply_stimulus(1'b0, 1'b1); enc_state = ST_Y; end
        else   begin apply_stimulus(1'b0, 1'b0); enc_state = ST_Z; end
      end
      ST_Y: begin
        if (b) apply_stimulus(1'b1, 1'b0);
        else   apply_stimulus(1'b0, 1'b1);
      end
      default: begin
        if (b) begin apply_stimulus(1'b0, 1'b1); enc_state = ST_Y; end
        else   begin apply_stimulus(1'b1, 1'b0); enc_state = ST_X; end
      end
    endcase
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i]);
  endtask

  logic [WIDTH-1:0] words [5];

  initial begin
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55;
    #1;

    $display("[TB] reset and idle line");
    apply_reset();
    apply_stimulus(1'b0, 1'b0);
    check_bit("idle_x_err", err, 1'b0);
    check_bit("idle_x_sync", sync, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    check_bit("idle_z_err", err, 1'b1);
    check_bit("idle_z_sync", sync, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    check_bit("idle_err_pulse", err, 1'b0);
    check_bit("idle_valid", out_valid, 1'b0);

    $display("[TB] decode A5 from X");
    apply_reset();
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b1, 1'b0);
    check_bit("a5_latency", out_valid, 1'b0);
    enc_state = ST_Y;
    send_bit(1'b1);
    check_bit("a5_valid", out_valid, 1'b1);
    check_word("a5_data", out_data, 8'hA5);
    send_bit(1'b0);
    check_bit("a5_popped", out_valid, 1'b0);

    // X,Z,X,Z,X then R in X decodes a 1: bits 0,0,0,0,1,0,0,0 -> 8'h10.
    $display("[TB] X/Z path");
    apply_reset();
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    check_bit("xz_sync", sync, 1'b1);
    check_bit("xz_err", err, 1'b0);
    enc_state = ST_Y;
    send_bit(1'b0);
    check_bit("xz_valid", out_valid, 1'b1);
    check_word("xz_data", out_data, 8'h10);

    $display("[TB] violation and resync");
    send_bit(1'b1);
    send_bit(1'b0);
    apply_stimulus(1'b0, 1'b0);
    check_bit("viol_err", err, 1'b1);
    check_bit("viol_sync", sync, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_bit("viol_n_err", err, 1'b0);
    check_bit("viol_n_sync", sync, 1'b0);
    apply_stimulus(1'b0, 1'b1);
    check_bit("resync_sync", sync, 1'b1);
    check_bit("resync_err", err, 1'b0);
    enc_state = ST_Y;
    send_word(8'h3C);
    check_bit("resync_latency", out_valid, 1'b0);
    send_bit(1'b0);
    check_bit("resync_valid", out_valid, 1'b1);
    check_word("resync_data", out_data, 8'h3C);

    $display("[TB] backpressure with overflow");
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_word(words[k]);
    check_bit("ovf_before_write", overflow, 1'b0);
    send_bit(1'b0);
    check_bit("ovf_set", overflow, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check_bit("ovf_drain_valid", out_valid, 1'b1);
      check_word("ovf_drain_data", out_data, words[k]);
      send_bit(1'b0);
    end
    check_bit("ovf_drained", out_valid, 1'b0);
    check_bit("ovf_sticky", overflow, 1'b1);

    $display("[TB] push and pop while full");
    apply_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(words[k]);
    send_word(words[4]);
    out_ready = 1'b1;
    check_bit("full_hold_data_valid", out_valid, 1'b1);
    check_word("full_hold_data", out_data, 8'h11);
    send_bit(1'b0);
    check_bit("pushpop_overflow", overflow, 1'b0);
    for (int k = 1; k < 5; k++) begin
      check_bit("pushpop_drain_valid", out_valid, 1'b1);
      check_word("pushpop_drain_data", out_data, words[k]);
      send_bit(1'b0);
    end
    check_bit("pushpop_drained", out_valid, 1'b0);

    $display("[TB] reset mid-word");
    apply_reset();
    out_ready = 1'b0;
    send_word(8'h5A);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check_bit("midword_fifo_valid", out_valid, 1'b1);
    apply_reset();
    out_ready = 1'b1;
    send_word(8'h96);
    check_bit("midword_latency", out_valid, 1'b0);
    send_bit(1'b0);
    check_bit("midword_valid", out_valid, 1'b1);
    check_word("midword_data", out_data, 8'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
